// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor:
// next-PC select codes, 2-bit counter states, index-width helper.
package bp_pkg;

    localparam logic [1:0] PC_SRC_PLUS4 = 2'b00;
    localparam logic [1:0] PC_SRC_PRED  = 2'b01;
    localparam logic [1:0] PC_SRC_EXTGT = 2'b10;
    localparam logic [1:0] PC_SRC_EXSEQ = 2'b11;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    // Index width for a power-of-two table size (at least 1 bit).
    function automatic int clog2_idx(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        if (w == 0) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/sat_counter2.sv
// One 2-bit saturating branch-history counter.
// Resets to weak-not-taken; inc wins if both enables are set.
module sat_counter2
    import bp_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_inc,
    input  logic       i_dec,
    output logic [1:0] o_state
);

    logic [1:0] r_state;

    // Saturating step toward strong-taken or strong-not-taken.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= WNT;
        end else if (i_inc) begin
            if (r_state != ST) begin
                r_state <= r_state + 2'd1;
            end
        end else if (i_dec) begin
            if (r_state != SNT) begin
                r_state <= r_state - 2'd1;
            end
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/branch_predict_unit.sv
// Per-PC dynamic branch predictor (BHT + tagged BTB) with
// EX-stage resolution, pipeline flush and PC redirect.
module branch_predict_unit
    import bp_pkg::*;
#(
    parameter int PC_WIDTH     = 64,
    parameter int BHT_ENTRIES  = 16,
    parameter int IDX_LSB      = 2,
    parameter int PREDICT_MODE = 1,
    parameter int STAT_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [PC_WIDTH-1:0]   if_pc,
    output logic                  if_pred_taken,
    output logic [PC_WIDTH-1:0]   if_pred_target,
    input  logic                  ex_valid,
    input  logic                  ex_branch,
    input  logic                  ex_taken,
    input  logic                  ex_pred_taken,
    input  logic [PC_WIDTH-1:0]   ex_pc,
    input  logic [PC_WIDTH-1:0]   ex_target,
    output logic [1:0]            pc_src,
    output logic [PC_WIDTH-1:0]   redirect_pc,
    output logic                  flush_ifid,
    output logic                  flush_idex,
    output logic [STAT_WIDTH-1:0] branch_count,
    output logic [STAT_WIDTH-1:0] mispredict_count
);

    localparam int IDX_W = clog2_idx(BHT_ENTRIES);
    localparam int TAG_W = PC_WIDTH - IDX_LSB - IDX_W;

    logic w_res;
    logic w_mispredict;
    logic w_pred_taken;
    logic [PC_WIDTH-1:0] w_pred_target;

    logic [STAT_WIDTH-1:0] r_branch_count;
    logic [STAT_WIDTH-1:0] r_mispredict_count;

    assign w_res = ex_valid && ex_branch;

    generate
        if (PREDICT_MODE != 0) begin : g_dyn
            logic [IDX_W-1:0] w_if_idx;
            logic [IDX_W-1:0] w_ex_idx;
            logic [TAG_W-1:0] w_if_tag;
            logic [TAG_W-1:0] w_ex_tag;
            logic [1:0]       w_bht [BHT_ENTRIES];
            logic             w_hit;

            logic                r_btb_valid  [BHT_ENTRIES];
            logic [TAG_W-1:0]    r_btb_tag    [BHT_ENTRIES];
            logic [PC_WIDTH-1:0] r_btb_target [BHT_ENTRIES];

            assign w_if_idx = if_pc[IDX_LSB +: IDX_W];
            assign w_ex_idx = ex_pc[IDX_LSB +: IDX_W];
            assign w_if_tag = if_pc[PC_WIDTH-1 -: TAG_W];
            assign w_ex_tag = ex_pc[PC_WIDTH-1 -: TAG_W];

            for (genvar i = 0; i < BHT_ENTRIES; i++) begin : g_bht
                logic w_sel;
                assign w_sel = w_res && (w_ex_idx == IDX_W'(i));

                sat_counter2 u_ctr (
                    .clk     (clk),
                    .reset   (reset),
                    .i_inc   (w_sel && ex_taken),
                    .i_dec   (w_sel && !ex_taken),
                    .o_state (w_bht[i])
                );
            end

            // BTB fill on every resolved taken branch; aliases are overwritten.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < BHT_ENTRIES; i++) begin
                        r_btb_valid[i]  <= 1'b0;
                        r_btb_tag[i]    <= '0;
                        r_btb_target[i] <= '0;
                    end
                end else if (w_res && ex_taken) begin
                    r_btb_valid[w_ex_idx]  <= 1'b1;
                    r_btb_tag[w_ex_idx]    <= w_ex_tag;
                    r_btb_target[w_ex_idx] <= ex_target;
                end
            end

            assign w_hit = r_btb_valid[w_if_idx]
                        && (r_btb_tag[w_if_idx] == w_if_tag);
            assign w_pred_taken  = w_hit && w_bht[w_if_idx][1];
            assign w_pred_target = r_btb_target[w_if_idx];
            assign w_mispredict  = w_res && (ex_taken != ex_pred_taken);

            if (IDX_LSB > 0) begin : g_lsb
                logic w_unused_lsb;
                assign w_unused_lsb = ^{if_pc[IDX_LSB-1:0]};
            end
        end else begin : g_static
            logic w_unused_st;
            assign w_unused_st   = ^{if_pc, ex_pred_taken};
            assign w_pred_taken  = 1'b0;
            assign w_pred_target = '0;
            assign w_mispredict  = w_res && ex_taken;
        end
    endgenerate

    assign if_pred_taken  = w_pred_taken;
    assign if_pred_target = w_pred_target;
    assign flush_ifid     = w_mispredict;
    assign flush_idex     = w_mispredict;

    // Next-PC select: EX mispredict beats the IF prediction.
    always_comb begin
        pc_src      = PC_SRC_PLUS4;
        redirect_pc = '0;
        if (w_mispredict) begin
            if (ex_taken) begin
                pc_src      = PC_SRC_EXTGT;
                redirect_pc = ex_target;
            end else begin
                pc_src      = PC_SRC_EXSEQ;
                redirect_pc = ex_pc + PC_WIDTH'(4);
            end
        end else if (w_pred_taken) begin
            pc_src = PC_SRC_PRED;
        end
    end

    // Resolved-branch and mispredict statistics, wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_branch_count     <= '0;
            r_mispredict_count <= '0;
        end else begin
            if (w_res) begin
                r_branch_count <= r_branch_count + STAT_WIDTH'(1);
            end
            if (w_mispredict) begin
                r_mispredict_count <= r_mispredict_count + STAT_WIDTH'(1);
            end
        end
    end

    assign branch_count     = r_branch_count;
    assign mispredict_count = r_mispredict_count;

endmodule
